// File: rtl/resp_misr_pkg.sv
// Shared definitions for the response-side MISR checker: state encodings
// and the default polynomial and seed.
package resp_misr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } misr_state_e;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'h0000;

endpackage

// File: rtl/resp_misr_step.sv
// One MISR update: shift left, fold the feedback taps in when the MSB falls
// out, then XOR in the incoming word. Purely combinational.
module misr_step #(
   parameter int unsigned           WIDTH = 16,
   parameter logic [WIDTH-1:0]      POLY  = 16'h1021
) (
   input  logic [WIDTH-1:0] sig_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] fb;

   always_comb begin
      fb     = sig_i[WIDTH-1] ? POLY : '0;
      next_o = ({sig_i[WIDTH-2:0], 1'b0} ^ fb) ^ din_i;
   end

endmodule

// File: rtl/resp_misr.sv
// Compacts a run of response words into a signature and compares it with a
// golden value latched at start.
//
// state | meaning
// IDLE  | waiting for start, no words accepted
// RUN   | accepting words until num_words have been compacted
// DONE  | signature and pass verdict held until the next start
module resp_misr
   import resp_misr_pkg::*;
#(
   parameter int unsigned      WIDTH   = 16,
   parameter logic [WIDTH-1:0] POLY    = MISR_POLY,
   parameter logic [WIDTH-1:0] SEED    = MISR_SEED,
   parameter int unsigned      COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] num_words,
   input  logic [WIDTH-1:0]   expected,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [WIDTH-1:0]   signature,
   output logic [COUNT_W-1:0] words_seen
);

   misr_state_e        state_q, state_d;
   logic [WIDTH-1:0]   sig_q, sig_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [COUNT_W-1:0] num_q, num_d;
   logic               pass_q, pass_d;
   logic               busy_q, done_q;
   logic [WIDTH-1:0]   sig_next;

   misr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .sig_i  (sig_q),
      .din_i  (in_data),
      .next_o (sig_next)
   );

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sig_d  = SEED;
               cnt_d  = '0;
               num_d  = num_words;
               exp_d  = expected;
               pass_d = 1'b0;
               if (num_words == '0) begin
                  state_d = DONE;
                  pass_d  = (SEED == expected);
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (in_valid) begin
               sig_d = sig_next;
               cnt_d = cnt_q + COUNT_W'(1);
               // Verdict uses the signature being written on this same edge.
               if (cnt_d == num_q) begin
                  state_d = DONE;
                  pass_d  = (sig_next == exp_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         exp_q   <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         pass_q  <= pass_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign in_ready   = (state_q == RUN);
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign signature  = sig_q;
   assign words_seen = cnt_q;

endmodule
